// File: rtl/cp0_exc_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// cp0_exc_unit
// Coprocessor-0 exception responder for the 5-stage MIPS core.
// Takes the M-stage exception report, ERET, hardware/timer interrupts and
// MTC0/MFC0 accesses. It commits EPC, Cause, Status and BadVAddr, then
// raises a registered one-cycle pipeline flush with a redirect PC.
// It also owns the Count/Compare timer interrupt.
//
// Ports
//   clk        core clock, rising edge
//   resetn     asynchronous active-low reset
//   Exc        M-stage exception valid
//   ExcCode    cause code (04 AdEL, 05 AdES, 08 Sys, 09 Bp, 0a RI, 0c Ov)
//   PC_M       PC of the M-stage instruction
//   BD_M       M-stage instruction sits in a branch delay slot
//   SL_Addr    M-stage load/store effective address
//   eret_M     ERET in the M stage
//   hw_int     level-sensitive hardware interrupt lines
//   cp0_addr   MTC0/MFC0 register number
//   cp0_wen    MTC0 write strobe
//   cp0_wdata  MTC0 write data
//   cp0_rdata  MFC0 read data, combinational from cp0_addr
//   exc_flush  registered flush of F..M plus redirect
//   exc_pc     registered redirect PC, valid while exc_flush is high
//   epc_out    current EPC
// ---------------------------------------------------------------------------
module cp0_exc_unit #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Exc,
    input  logic [4:0]  ExcCode,
    input  logic [31:0] PC_M,
    input  logic        BD_M,
    input  logic [31:0] SL_Addr,
    input  logic        eret_M,
    input  logic [5:0]  hw_int,
    input  logic [4:0]  cp0_addr,
    input  logic        cp0_wen,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        exc_flush,
    output logic [31:0] exc_pc,
    output logic [31:0] epc_out
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    // BEV is read-only and fixed at its reset value
    localparam logic STATUS_BEV = STATUS_RST[22];

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t state;
    state_t state_next;

    // architectural state
    logic [31:0] badvaddr;
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] epc;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc_code;
    logic        tick;

    // combinational helpers
    logic [31:0] status_rd;
    logic [31:0] cause_rd;
    logic        int_req;
    logic        take_int;
    logic        take_exc;
    logic        take_eret;
    logic        mtc0_en;
    logic        wr_status;
    logic        wr_cause;
    logic        wr_epc;
    logic        wr_count;
    logic        wr_compare;
    logic [31:0] count_inc;
    logic        timer_hit;
    logic        flush_next;
    logic [31:0] exc_pc_next;

    assign status_rd = {9'd0, STATUS_BEV, 6'd0, status_im, 6'd0, status_exl, status_ie};
    assign cause_rd  = {cause_bd, cause_ti, 14'd0, cause_ip_hw, cause_ip_sw,
                        1'b0, cause_exc_code, 2'b00};

    assign int_req = status_ie & ~status_exl &
                     (|({cause_ip_hw, cause_ip_sw} & status_im));

    // MTC0 only lands in IDLE, and is dropped when the same cycle raises an
    // interrupt or exception. ERET does not block it, so an EPC write in the
    // ERET cycle is both committed and used as the return address.
    assign mtc0_en    = cp0_wen & (state == IDLE) & ~int_req & ~Exc;
    assign wr_status  = mtc0_en & (cp0_addr == REG_STATUS);
    assign wr_cause   = mtc0_en & (cp0_addr == REG_CAUSE);
    assign wr_epc     = mtc0_en & (cp0_addr == REG_EPC);
    assign wr_count   = mtc0_en & (cp0_addr == REG_COUNT);
    assign wr_compare = mtc0_en & (cp0_addr == REG_COMPARE);

    // Count advances every other cycle; a match is only recognised on an
    // actual increment, so a freshly written Count never fires the timer.
    assign count_inc = count + 32'd1;
    assign timer_hit = tick & ~wr_count & (count_inc == compare);

    assign epc_out = epc;

    // MFC0 read mux
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            REG_BADVADDR: cp0_rdata = badvaddr;
            REG_COUNT:    cp0_rdata = count;
            REG_COMPARE:  cp0_rdata = compare;
            REG_STATUS:   cp0_rdata = status_rd;
            REG_CAUSE:    cp0_rdata = cause_rd;
            REG_EPC:      cp0_rdata = epc;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, event selection (int > Exc > ERET) and redirect target
    always_comb begin
        state_next  = state;
        flush_next  = 1'b0;
        exc_pc_next = exc_pc;
        take_int    = 1'b0;
        take_exc    = 1'b0;
        take_eret   = 1'b0;
        case (state)
            IDLE: begin
                if (int_req) begin
                    take_int = 1'b1;
                end else if (Exc) begin
                    take_exc = 1'b1;
                end else if (eret_M) begin
                    take_eret = 1'b1;
                end
                if (take_int || take_exc || take_eret) begin
                    state_next = FLUSH;
                    flush_next = 1'b1;
                end
                if (take_int || take_exc) begin
                    exc_pc_next = EXC_VECTOR;
                end else if (take_eret) begin
                    exc_pc_next = wr_epc ? cp0_wdata : epc;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered flush and redirect PC
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exc_flush <= 1'b0;
            exc_pc    <= 32'd0;
        end else begin
            exc_flush <= flush_next;
            exc_pc    <= exc_pc_next;
        end
    end

    // Count/Compare timer; writing Compare acknowledges the timer interrupt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count    <= 32'd0;
            compare  <= 32'd0;
            tick     <= 1'b0;
            cause_ti <= 1'b0;
        end else begin
            tick <= ~tick;
            if (tick) begin
                count <= count_inc;
            end
            if (timer_hit) begin
                cause_ti <= 1'b1;
            end
            if (wr_count) begin
                count <= cp0_wdata;
                tick  <= 1'b0;
            end
            if (wr_compare) begin
                compare  <= cp0_wdata;
                cause_ti <= 1'b0;
            end
        end
    end

    // Pending-interrupt sampling; IP7 also carries the timer interrupt
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cause_ip_hw <= 6'd0;
        end else begin
            cause_ip_hw <= {hw_int[5] | cause_ti, hw_int[4:0]};
        end
    end

    // Status, Cause, EPC and BadVAddr commit. Event updates come after MTC0
    // updates so they take precedence where both touch the same field.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im      <= STATUS_RST[15:8];
            status_exl     <= STATUS_RST[1];
            status_ie      <= STATUS_RST[0];
            cause_bd       <= 1'b0;
            cause_ip_sw    <= 2'b00;
            cause_exc_code <= 5'd0;
            epc            <= 32'd0;
            badvaddr       <= 32'd0;
        end else begin
            if (wr_status) begin
                status_im  <= cp0_wdata[15:8];
                status_exl <= cp0_wdata[1];
                status_ie  <= cp0_wdata[0];
            end
            if (wr_cause) begin
                cause_ip_sw <= cp0_wdata[9:8];
            end
            if (wr_epc) begin
                epc <= cp0_wdata;
            end
            if (take_int || take_exc) begin
                // a nested exception keeps the original return point
                if (!status_exl) begin
                    epc      <= BD_M ? (PC_M - 32'd4) : PC_M;
                    cause_bd <= BD_M;
                end
                cause_exc_code <= take_int ? EXC_INT : ExcCode;
                status_exl     <= 1'b1;
                // a misaligned PC means the fault was the fetch, not the data access
                if (take_exc && ((ExcCode == EXC_ADEL) || (ExcCode == EXC_ADES))) begin
                    badvaddr <= (PC_M[1:0] != 2'b00) ? PC_M : SL_Addr;
                end
            end else if (take_eret) begin
                status_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cp0_exc_unit
// Self-checking bench for cp0_exc_unit. Every event that should produce a
// flush pushes its expected redirect PC and EPC onto a queue; a monitor pops
// and compares whenever the DUT raises exc_flush. Register state is checked
// through the MFC0 read port against values derived here.
// ---------------------------------------------------------------------------
module tb_cp0_exc_unit;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk;
    logic        resetn;
    logic        Exc;
    logic [4:0]  ExcCode;
    logic [31:0] PC_M;
    logic        BD_M;
    logic [31:0] SL_Addr;
    logic        eret_M;
    logic [5:0]  hw_int;
    logic [4:0]  cp0_addr;
    logic        cp0_wen;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        exc_flush;
    logic [31:0] exc_pc;
    logic [31:0] epc_out;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] epc;
    } exp_t;

    exp_t expQ[$];
    exp_t expItem;

    int totalChecks = 0;
    int passCount   = 0;

    cp0_exc_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .Exc       (Exc),
        .ExcCode   (ExcCode),
        .PC_M      (PC_M),
        .BD_M      (BD_M),
        .SL_Addr   (SL_Addr),
        .eret_M    (eret_M),
        .hw_int    (hw_int),
        .cp0_addr  (cp0_addr),
        .cp0_wen   (cp0_wen),
        .cp0_wdata (cp0_wdata),
        .cp0_rdata (cp0_rdata),
        .exc_flush (exc_flush),
        .exc_pc    (exc_pc),
        .epc_out   (epc_out)
    );

    // 20 ns clock, rising edges at 10, 30, 50, ...
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // drive one cycle of M-stage activity; strobes drop after the edge
    task automatic applyStimulus(input logic exc, input logic [4:0] code,
                                 input logic [31:0] pc, input logic bd,
                                 input logic [31:0] sl, input logic eret,
                                 input logic wen, input logic [4:0] addr,
                                 input logic [31:0] wdata);
        Exc       = exc;
        ExcCode   = code;
        PC_M      = pc;
        BD_M      = bd;
        SL_Addr   = sl;
        eret_M    = eret;
        cp0_wen   = wen;
        cp0_addr  = addr;
        cp0_wdata = wdata;
        stepCycle();
        Exc     = 1'b0;
        eret_M  = 1'b0;
        cp0_wen = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, addr, wdata);
    endtask

    task automatic expectFlush(input logic [31:0] pc, input logic [31:0] epc);
        exp_t e;
        e.pc  = pc;
        e.epc = epc;
        expQ.push_back(e);
    endtask

    task automatic checkReg(input string tag, input logic [4:0] addr,
                            input logic [31:0] expected);
        cp0_addr = addr;
        #1;
        checkOutput(tag, cp0_rdata, expected);
    endtask

    // scoreboard monitor: every flush cycle must match the oldest expectation
    always @(negedge clk) begin
        if (resetn && exc_flush) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_flush", {31'd0, exc_flush}, 32'd0);
            end else begin
                expItem = expQ.pop_front();
                checkOutput("exc_pc", exc_pc, expItem.pc);
                checkOutput("epc_out", epc_out, expItem.epc);
            end
        end
    end

    initial begin
        resetn    = 1'b0;
        Exc       = 1'b0;
        ExcCode   = 5'd0;
        PC_M      = 32'd0;
        BD_M      = 1'b0;
        SL_Addr   = 32'd0;
        eret_M    = 1'b0;
        hw_int    = 6'd0;
        cp0_addr  = 5'd0;
        cp0_wen   = 1'b0;
        cp0_wdata = 32'd0;

        // reset state
        stepCycle();
        stepCycle();
        checkOutput("rst_flush", {31'd0, exc_flush}, 32'd0);
        checkOutput("rst_exc_pc", exc_pc, 32'd0);
        checkReg("rst_status", 5'd12, 32'h0040_0000);
        checkReg("rst_cause", 5'd13, 32'd0);
        checkReg("rst_epc", 5'd14, 32'd0);
        checkReg("rst_count", 5'd9, 32'd0);
        checkReg("rst_compare", 5'd11, 32'd0);
        checkReg("rst_badvaddr", 5'd8, 32'd0);
        resetn = 1'b1;
        stepCycle();

        // register map, writable masks, read-only BEV
        checkReg("unmapped_5", 5'd5, 32'd0);
        checkReg("unmapped_15", 5'd15, 32'd0);
        mtc0(5'd12, 32'hFFBF_FFFE);
        checkReg("status_mask", 5'd12, 32'h0040_FF02);
        mtc0(5'd12, 32'h0000_0000);
        checkReg("status_clear", 5'd12, 32'h0040_0000);
        mtc0(5'd13, 32'hFFFF_FFFF);
        checkReg("cause_mask", 5'd13, 32'h0000_0300);
        mtc0(5'd13, 32'h0000_0000);

        // overflow exception; concurrent MTC0 Compare must be dropped
        expectFlush(VEC, 32'h8000_0100);
        applyStimulus(1'b1, 5'h0c, 32'h8000_0100, 1'b0, 32'd0, 1'b0,
                      1'b1, 5'd11, 32'h0000_1234);
        checkOutput("t1_flush_on", {31'd0, exc_flush}, 32'd1);
        stepCycle();
        checkOutput("t1_flush_off", {31'd0, exc_flush}, 32'd0);
        checkReg("t1_cause", 5'd13, 32'h0000_0030);
        checkReg("t1_status", 5'd12, 32'h0040_0002);
        checkReg("t1_compare_kept", 5'd11, 32'd0);

        expectFlush(32'h8000_0100, 32'h8000_0100);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checkReg("eret1_status", 5'd12, 32'h0040_0000);

        // AdEL in a delay slot with a misaligned PC
        expectFlush(VEC, 32'h8000_01FE);
        applyStimulus(1'b1, 5'h04, 32'h8000_0202, 1'b1, 32'h0000_2000, 1'b0,
                      1'b0, 5'd0, 32'd0);
        stepCycle();
        checkReg("t2_badvaddr_pc", 5'd8, 32'h8000_0202);
        checkReg("t2_cause_bd", 5'd13, 32'h8000_0010);

        expectFlush(32'h8000_01FE, 32'h8000_01FE);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        stepCycle();

        // AdES with an aligned PC takes the data address
        expectFlush(VEC, 32'h8000_0300);
        applyStimulus(1'b1, 5'h05, 32'h8000_0300, 1'b0, 32'h0000_1003, 1'b0,
                      1'b0, 5'd0, 32'd0);
        stepCycle();
        checkReg("t2_badvaddr_sl", 5'd8, 32'h0000_1003);
        checkReg("t2_cause_ades", 5'd13, 32'h0000_0014);

        // nested syscall with EXL already set: EPC and BD hold
        expectFlush(VEC, 32'h8000_0300);
        applyStimulus(1'b1, 5'h08, 32'h8000_0600, 1'b1, 32'd0, 1'b0,
                      1'b0, 5'd0, 32'd0);
        stepCycle();
        checkReg("t3_cause", 5'd13, 32'h0000_0020);
        checkReg("t3_status", 5'd12, 32'h0040_0002);
        checkReg("t3_badvaddr_kept", 5'd8, 32'h0000_1003);

        expectFlush(32'h8000_0300, 32'h8000_0300);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        stepCycle();
        checkReg("t3_eret_status", 5'd12, 32'h0040_0000);

        // ERET with MTC0 EPC in the same cycle returns to the new EPC
        expectFlush(32'h8000_0700, 32'h8000_0700);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1,
                      1'b1, 5'd14, 32'h8000_0700);
        stepCycle();
        checkReg("eret_mtc0_epc", 5'd14, 32'h8000_0700);

        // timer interrupt: Count runs 0,0,1,1,... so it reaches 4 eight edges
        // after the Count write; IP7 is sampled one edge later, the event one
        // edge after that
        mtc0(5'd12, 32'h0000_8000);
        mtc0(5'd11, 32'h0000_0004);
        mtc0(5'd9, 32'h0000_0000);
        mtc0(5'd12, 32'h0000_8001);
        PC_M = 32'h8000_0400;
        BD_M = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stepCycle();
        end
        checkReg("t4_ti_before", 5'd13, 32'h0000_0020);
        expectFlush(VEC, 32'h8000_0400);
        stepCycle();
        checkReg("t4_ti_set", 5'd13, 32'h4000_0020);
        checkReg("t4_count", 5'd9, 32'h0000_0004);
        stepCycle();
        checkOutput("t4_no_flush_yet", {31'd0, exc_flush}, 32'd0);
        stepCycle();
        checkOutput("t4_flush", {31'd0, exc_flush}, 32'd1);
        stepCycle();
        checkReg("t4_cause_int", 5'd13, 32'h4000_8000);
        checkReg("t4_status", 5'd12, 32'h0040_8003);
        mtc0(5'd11, 32'hFFFF_0000);
        cp0_addr = 5'd13;
        #1;
        checkOutput("t4_ti_clear", cp0_rdata & 32'h4000_0000, 32'd0);
        stepCycle();
        checkReg("t4_ip7_clear", 5'd13, 32'h0000_0000);

        expectFlush(32'h8000_0400, 32'h8000_0400);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
        stepCycle();

        // interrupt and exception together: interrupt wins; Exc held into
        // the FLUSH cycle must be ignored
        mtc0(5'd12, 32'h0000_8401);
        hw_int = 6'b000001;
        stepCycle();
        Exc     = 1'b1;
        ExcCode = 5'h0c;
        PC_M    = 32'h8000_0500;
        BD_M    = 1'b0;
        expectFlush(VEC, 32'h8000_0500);
        stepCycle();
        stepCycle();
        Exc = 1'b0;
        stepCycle();
        checkReg("t5_cause_int", 5'd13, 32'h0000_0400);
        checkReg("t5_status", 5'd12, 32'h0040_8403);
        checkReg("t5_epc", 5'd14, 32'h8000_0500);

        // reset while in FLUSH
        Exc     = 1'b1;
        ExcCode = 5'h04;
        PC_M    = 32'h8000_0801;
        SL_Addr = 32'd0;
        @(posedge clk);
        #2;
        resetn = 1'b0;
        Exc    = 1'b0;
        hw_int = 6'd0;
        #1;
        checkOutput("t6_flush", {31'd0, exc_flush}, 32'd0);
        checkOutput("t6_exc_pc", exc_pc, 32'd0);
        checkReg("t6_status", 5'd12, 32'h0040_0000);
        checkReg("t6_cause", 5'd13, 32'd0);
        checkReg("t6_epc", 5'd14, 32'd0);
        checkReg("t6_badvaddr", 5'd8, 32'd0);
        checkReg("t6_compare", 5'd11, 32'd0);
        stepCycle();
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
        end
        checkOutput("t6_after_flush", {31'd0, exc_flush}, 32'd0);
        checkReg("t6_after_status", 5'd12, 32'h0040_0000);

        checkOutput("queue_empty", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalChecks);
        $finish;
    end

endmodule
